frac_decim: RTL and testbench
=============================

# frac_decim

Source-driven fractional step generator for the downscaling path of the scandoubler/scaler. It pairs with the destination-driven upscale interpolator. It consumes one strobe per incoming source pixel and emits a destination strobe whenever the accumulated source coverage crosses a destination-pixel boundary. With each destination strobe it reports the carried-over fraction, which the blender uses as a weight. It contains its own serial divider, so a new scale ratio costs one division and no multipliers.

## Interface
- bitwidth, 10: width of span counts num/den/whole.
- fracwidth, 16: width of fractional accumulator, step and fraction output.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- num  in  bitwidth  source span length in pixels (larger value); sampled on newfraction.
- den  in  bitwidth  destination span length in pixels (smaller value); sampled on newfraction.
- newfraction  in  1  one-cycle pulse: latch num/den, start division, clear position state.
- ready  out  1  step value valid; step_in is honoured only while high.
- step_reset  in  1  start of span: clear position state, keep step.
- step_in  in  1  one source pixel consumed.
- step_out  out  1  one-cycle pulse: one destination pixel completed.
- whole  out  bitwidth  destination pixels emitted in the current span.
- fraction  out  fracwidth  coverage of the current source pixel that spills into the next destination pixel; valid with step_out.
- last  out  1  one-cycle pulse coincident with the step_out that makes whole equal to den.

## Operation
- Division: step = floor((den << fracwidth) / num), restoring, one quotient bit per cycle, bitwidth+fracwidth iterations, dividend/quotient width bitwidth+fracwidth.
- Saturation: if the quotient is ≥ 2^fracwidth (den ≥ num), step = 2^fracwidth−1.
- num == 0: step = 0, ready still rises on schedule.
- newfraction during a division restarts it with the new num/den; ready stays low.
- Position state: acc (fracwidth), spos (bitwidth source count), whole.
- On each accepted step_in (ready high, no step_reset/newfraction same cycle):
  - Form sum = acc + step (fracwidth+1 bits). Set acc ← sum[fracwidth−1:0]. Set spos ← spos+1.
  - Carry (sum[fracwidth] = 1) and whole < den: step_out = 1, fraction = sum[fracwidth−1:0], whole ← whole+1.
  - Flush: if spos == num−1 (last source pixel), whole < den and there is no carry, force step_out = 1, fraction = 0, whole ← whole+1. This recovers truncation loss.
  - whole == den: saturated. No further step_out. acc/spos still advance.
  - last = 1 when the step_out increments whole to den.
- den == 0: step_out never asserts.
- step_in while ready low is ignored; no state changes.
- Priority (highest first): reset_n low, newfraction, step_reset, step_in.

## Timing
- Reset values: ready 0, step_out 0, last 0, whole 0, fraction 0; internal acc/spos/step 0, divider idle.
- newfraction on edge N: ready 0 after edge N. ready 1 after edge N+bitwidth+fracwidth+1 (27 for defaults), and stays high until the next newfraction or reset.
- step_out, last, fraction and whole update on the edge that samples step_in (one-cycle registered latency). step_out/last self-clear the following cycle unless re-triggered.
- fraction holds its value between strobes and is cleared to 0 by step_reset/newfraction.
- Back-to-back step_in every cycle is supported; at most one step_out per step_in.
- Asynchronous reset mid-division or mid-span aborts immediately. After release, ready stays 0 until a newfraction completes.

## Test plan
- Reset/ready: reset, newfraction with num=4, den=2 at edge 0 -> ready 0 through edge 26, 1 from edge 27; step=0x8000.
- Exact ratio: num=4, den=2, four step_in -> step_out after pixels 2 and 4, fraction 0 both times, whole 1 then 2, last on pixel 4 only.
- Truncation flush: num=3, den=2 (step=0xAAAA), three step_in -> pixel 2 step_out with fraction 0x5554, whole=1. Pixel 3 acc=0xFFFE with no carry, but flush forces step_out, fraction 0, whole=2, last=1.
- Saturation/edges: num=2, den=5 -> step 0xFFFF; step_in continued past whole==den gives no extra step_out. den=0 -> no step_out across 10 step_in.
- Gating/priority: step_in while ready low is ignored (whole stays 0). step_reset with step_in on the same edge -> whole 0, no step_out. newfraction mid-division restarts it, and ready rises 27 edges after the last newfraction.
- Async reset mid-span: num=8, den=3, assert reset_n low between clock edges after 5 step_in -> all outputs 0 immediately, ready remains 0 until a new newfraction completes.

Source files
------------

// File: rtl/frac_decim.sv
// Purpose : source-driven fractional step generator for downscaling; serial divider derives the per-pixel step.
// Latency : ready rises bitwidth+fracwidth+1 cycles after newfraction; step_out/fraction/whole/last one cycle after step_in.
// Backpressure: none on outputs; step_in is ignored while ready is low.
module frac_decim #(
    parameter int bitwidth  = 10,
    parameter int fracwidth = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [bitwidth-1:0]  num,
    input  logic [bitwidth-1:0]  den,
    input  logic                 newfraction,
    output logic                 ready,
    input  logic                 step_reset,
    input  logic                 step_in,
    output logic                 step_out,
    output logic [bitwidth-1:0]  whole,
    output logic [fracwidth-1:0] fraction,
    output logic                 last
);

    localparam int DW = bitwidth + fracwidth;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

    state_t               state, state_nxt;
    logic [bitwidth-1:0]  num_q, den_q;
    logic [DW-1:0]        dvd, quo;
    logic [bitwidth-1:0]  rem, rem_nxt;
    logic [bitwidth:0]    rem_sh, rem_diff;
    logic                 q_bit;
    logic [CW-1:0]        cnt;
    logic [fracwidth-1:0] step, step_nxt;

    logic [fracwidth-1:0] acc;
    logic [bitwidth-1:0]  spos;
    logic [fracwidth:0]   sum;
    logic                 carry, flush;
    logic [bitwidth-1:0]  whole_inc;

    // Divider state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Divider sequencing: run DW iterations, one finalise cycle, restart on any newfraction.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_IDLE;
            S_DIV:  if (cnt == CW'(DW - 1)) state_nxt = S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (newfraction) state_nxt = S_DIV;
    end

    // One restoring iteration: shift in next dividend bit, subtract num if it fits.
    always_comb begin
        rem_sh   = {rem, dvd[DW-1]};
        rem_diff = rem_sh - {1'b0, num_q};
        q_bit    = (rem_sh >= {1'b0, num_q});
        rem_nxt  = q_bit ? rem_diff[bitwidth-1:0] : rem_sh[bitwidth-1:0];
        // num==0 would yield an all-ones quotient; force step to zero instead.
        if (num_q == '0)                  step_nxt = '0;
        else if (|quo[DW-1:fracwidth])    step_nxt = '1;
        else                              step_nxt = quo[fracwidth-1:0];
    end

    // Divider datapath and step/ready registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_q <= '0; den_q <= '0; dvd <= '0; quo <= '0;
            rem   <= '0; cnt   <= '0; step <= '0; ready <= 1'b0;
        end else if (newfraction) begin
            num_q <= num;
            den_q <= den;
            dvd   <= {den, {fracwidth{1'b0}}};
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == S_DIV) begin
            rem <= rem_nxt;
            dvd <= {dvd[DW-2:0], 1'b0};
            quo <= {quo[DW-2:0], q_bit};
            cnt <= cnt + CW'(1);
        end else if (state == S_FIN) begin
            step  <= step_nxt;
            ready <= 1'b1;
        end
    end

    // Accumulator sum, carry and last-source-pixel flush condition.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, step};
        carry     = sum[fracwidth];
        flush     = (spos == (num_q - bitwidth'(1)));
        whole_inc = whole + bitwidth'(1);
    end

    // Position tracking and destination strobe generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0; spos <= '0; whole <= '0; fraction <= '0;
            step_out <= 1'b0; last <= 1'b0;
        end else if (newfraction || step_reset) begin
            acc <= '0; spos <= '0; whole <= '0; fraction <= '0;
            step_out <= 1'b0; last <= 1'b0;
        end else begin
            step_out <= 1'b0;
            last     <= 1'b0;
            if (ready && step_in) begin
                acc  <= sum[fracwidth-1:0];
                spos <= spos + bitwidth'(1);
                // Once whole reaches den the span is saturated and strobes stop.
                if ((whole < den_q) && (carry || flush)) begin
                    step_out <= 1'b1;
                    fraction <= carry ? sum[fracwidth-1:0] : '0;
                    whole    <= whole_inc;
                    last     <= (whole_inc == den_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_frac_decim.sv
module tb_frac_decim;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  num, den;
    logic        newfraction, step_reset, step_in;
    logic        ready, step_out, last;
    logic [9:0]  whole;
    logic [15:0] fraction;

    frac_decim #(.bitwidth(10), .fracwidth(16)) dut (
        .clk(clk), .reset_n(reset_n), .num(num), .den(den),
        .newfraction(newfraction), .ready(ready), .step_reset(step_reset),
        .step_in(step_in), .step_out(step_out), .whole(whole),
        .fraction(fraction), .last(last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int frac;
        int whl;
        int lst;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // reference model state (plain integers)
    int m_num, m_den, m_step, m_acc, m_spos, m_whole;
    bit m_ready;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_step(input int n, input int d);
        int v;
        if (n == 0) return 0;
        v = (d * 65536) / n;
        return (v > 65535) ? 65535 : v;
    endfunction

    // Model of one cycle of position logic as the spec describes it.
    task automatic model_apply(input bit sr, input bit si);
        int   s, prev;
        exp_t e;
        if (sr) begin
            m_acc = 0; m_spos = 0; m_whole = 0;
        end else if (si && m_ready) begin
            s      = m_acc + m_step;
            prev   = m_spos;
            m_acc  = s % 65536;
            m_spos = (m_spos + 1) % 1024;
            if (m_whole < m_den) begin
                if (s >= 65536 || prev == m_num - 1) begin
                    m_whole = m_whole + 1;
                    e.frac  = (s >= 65536) ? (s % 65536) : 0;
                    e.whl   = m_whole;
                    e.lst   = (m_whole == m_den) ? 1 : 0;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic step_cyc(input bit sr, input bit si);
        @(negedge clk);
        step_reset = sr;
        step_in    = si;
        model_apply(sr, si);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            step_reset = 1'b0;
            step_in    = 1'b0;
        end
    endtask

    task automatic do_newfrac(input int n, input int d);
        @(negedge clk);
        num = 10'(n); den = 10'(d);
        newfraction = 1'b1; step_in = 1'b0; step_reset = 1'b0;
        m_num = n; m_den = d; m_step = ref_step(n, d);
        m_acc = 0; m_spos = 0; m_whole = 0; m_ready = 0;
        @(negedge clk);
        newfraction = 1'b0;
        chk("ready_low_after_nf", 32'(ready), 0);
        chk("whole_clr_nf", 32'(whole), 0);
        chk("fraction_clr_nf", 32'(fraction), 0);
        repeat (26) @(negedge clk);
        chk("ready_low_edge26", 32'(ready), 0);
        @(negedge clk);
        chk("ready_high_edge27", 32'(ready), 1);
        m_ready = 1;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step_cyc(1'b0, 1'b1);
        idle(2);
        chk("queue_drained", q.size(), 0);
        chk("whole_end", 32'(whole), m_whole);
    endtask

    // Monitor: every destination strobe must match the next expected entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (step_out) begin
                if (q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_step_out: whole=%0d fraction=0x%0h expected none at %0t",
                             whole, fraction, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("fraction", 32'(fraction), e.frac);
                    chk("whole", 32'(whole), e.whl);
                    chk("last", 32'(last), e.lst);
                end
            end else if (last) begin
                n_cmp++; n_fail++;
                $display("FAIL last_without_step_out: last=1 step_out=0 at %0t", $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d;
        reset_n = 1'b0; num = '0; den = '0;
        newfraction = 1'b0; step_reset = 1'b0; step_in = 1'b0;
        m_ready = 0; m_num = 0; m_den = 0; m_step = 0;
        m_acc = 0; m_spos = 0; m_whole = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_step_out", 32'(step_out), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_whole", 32'(whole), 0);
        chk("rst_fraction", 32'(fraction), 0);
        reset_n = 1'b1;

        // exact ratio
        do_newfrac(4, 2);
        run_steps(4);
        // truncation flush
        do_newfrac(3, 2);
        run_steps(3);
        // saturated step, stepping past whole==den
        do_newfrac(2, 5);
        run_steps(9);
        // den == 0
        do_newfrac(6, 0);
        run_steps(10);

        // step_reset wins over step_in on the same edge
        do_newfrac(4, 2);
        step_cyc(1'b0, 1'b1);
        step_cyc(1'b0, 1'b1);
        step_cyc(1'b1, 1'b1);
        idle(2);
        chk("whole_after_step_reset", 32'(whole), 0);
        chk("fraction_after_step_reset", 32'(fraction), 0);
        run_steps(4);

        // newfraction mid-division restarts it
        @(negedge clk);
        num = 10'd5; den = 10'd1; newfraction = 1'b1; m_ready = 0;
        @(negedge clk);
        newfraction = 1'b0;
        repeat (10) @(negedge clk);
        chk("ready_low_mid_div", 32'(ready), 0);
        do_newfrac(4, 2);
        run_steps(4);

        // async reset mid-span
        do_newfrac(8, 3);
        for (int i = 0; i < 5; i++) step_cyc(1'b0, 1'b1);
        idle(2);
        chk("whole_before_areset", 32'(whole), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_ready", 32'(ready), 0);
        chk("areset_step_out", 32'(step_out), 0);
        chk("areset_whole", 32'(whole), 0);
        chk("areset_fraction", 32'(fraction), 0);
        chk("areset_last", 32'(last), 0);
        m_ready = 0; m_acc = 0; m_spos = 0; m_whole = 0;
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        // step_in while ready is low must be ignored
        for (int i = 0; i < 3; i++) step_cyc(1'b0, 1'b1);
        idle(2);
        chk("ready_low_after_areset", 32'(ready), 0);
        chk("whole_gated", 32'(whole), 0);
        do_newfrac(8, 3);
        run_steps(8);

        // randomized spans
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 40);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 60) : $urandom_range(0, n);
            do_newfrac(n, d);
            for (int i = 0; i < n + 4; i++)
                step_cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0));
            idle(2);
            chk("rand_drained", q.size(), 0);
            chk("rand_whole", 32'(whole), m_whole);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
